uart_mem_master: RTL and testbench

- Byte-stream command decoder that acts as a bus initiator on the 32-bit mem interface (valid/addr/wdata/wstrb/ready/rdata) used by the RISC-V peripherals.
- It sits behind a UART receiver/transmitter pair as a debug/boot loader. It turns serial command frames into single-word bus reads and writes, and returns responses as bytes.
- It is the initiator counterpart of the mem-slave UART peripheral.

---
 rtl/uart_mem_master.sv | 203 ++++++++++++++++++++
 tb/tb_uart_mem_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_master.sv
// uart_mem_master
// Debug/boot-loader bridge: decodes command frames arriving as a byte stream
// from a UART receiver and runs single-word transfers on the 32-bit mem bus as
// an initiator. Each transfer is answered with response bytes for the UART
// transmitter.
//
// Frames (multi-byte fields MSB first):
//   0x57 A3 A2 A1 A0 D3 D2 D1 D0 -> bus write, response 0x06
//   0x52 A3 A2 A1 A0             -> bus read,  response R3 R2 R1 R0
//   any other command byte       -> response 0x15, no bus activity
//   bus timeout                  -> response 0x15
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   rx_valid, rx_data     received-byte strobe and byte
//   tx_valid, tx_data     response byte offered to the transmitter
//   tx_ready              transmitter accepts when tx_valid && tx_ready
//   mem_m_valid/addr/wdata/wstrb  bus request (wstrb 4'hF write, 4'h0 read)
//   mem_m_ready/rdata     slave completion and read data
//   busy                  registered (state != IDLE)
//   err_ovf               sticky: a byte arrived in BUS or RESP and was dropped
//
// Parameter:
//   TIMEOUT               bus cycles to wait for mem_m_ready (2..65535)

module uart_mem_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_m_valid,
  output logic [31:0] mem_m_addr,
  output logic [31:0] mem_m_wdata,
  output logic [3:0]  mem_m_wstrb,
  input  logic        mem_m_ready,
  input  logic [31:0] mem_m_rdata,
  output logic        busy,
  output logic        err_ovf
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

  localparam logic [7:0]  CMD_WR       = 8'h57;
  localparam logic [7:0]  CMD_RD       = 8'h52;
  localparam logic [7:0]  RSP_ACK      = 8'h06;
  localparam logic [7:0]  RSP_NAK      = 8'h15;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_q;
  logic [1:0]  resp_cnt;
  logic [1:0]  resp_last;
  logic [15:0] timer;
  logic        cmd_known;
  logic        timeout_hit;

  assign cmd_known   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign timeout_hit = (timer == TIMEOUT_LAST);

  // State register. Reset returns to IDLE, which discards a partial frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The fourth address/data byte moves on in the same
  // cycle it is accepted, so mem_m_valid rises one cycle after the last byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          state_next = cmd_known ? ADDR : RESP;
        end
      end
      ADDR: begin
        if (rx_valid && (byte_cnt == 2'd3)) begin
          state_next = is_write ? DATA : BUS;
        end
      end
      DATA: begin
        if (rx_valid && (byte_cnt == 2'd3)) begin
          state_next = BUS;
        end
      end
      BUS: begin
        if (mem_m_ready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (tx_ready && (resp_cnt == resp_last)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte shifters for address and write data, bus timer, and the
  // response shift register whose top byte is always the byte on offer.
  // busy tracks state_next so that it equals (state != IDLE) as a flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_write  <= 1'b0;
      byte_cnt  <= 2'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      resp_q    <= 32'h0;
      resp_cnt  <= 2'd0;
      resp_last <= 2'd0;
      timer     <= 16'h0;
      busy      <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (rx_valid && ((state == BUS) || (state == RESP))) begin
        err_ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rx_valid) begin
            is_write <= (rx_data == CMD_WR);
            byte_cnt <= 2'd0;
            timer    <= 16'h0;
            resp_cnt <= 2'd0;
            if (!cmd_known) begin
              resp_q    <= {RSP_NAK, 24'h0};
              resp_last <= 2'd0;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_q   <= {addr_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            wdata_q  <= {wdata_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        BUS: begin
          resp_cnt <= 2'd0;
          if (mem_m_ready) begin
            if (is_write) begin
              resp_q    <= {RSP_ACK, 24'h0};
              resp_last <= 2'd0;
            end else begin
              resp_q    <= mem_m_rdata;
              resp_last <= 2'd3;
            end
          end else if (timeout_hit) begin
            resp_q    <= {RSP_NAK, 24'h0};
            resp_last <= 2'd0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RESP: begin
          if (tx_ready) begin
            resp_q   <= {resp_q[23:0], 8'h00};
            resp_cnt <= resp_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register, so reset drops mem_m_valid and
  // tx_valid immediately without waiting for a clock edge.
  always_comb begin
    tx_valid    = (state == RESP);
    tx_data     = (state == RESP) ? resp_q[31:24] : 8'h00;
    mem_m_valid = (state == BUS);
    mem_m_wstrb = ((state == BUS) && is_write) ? 4'hF : 4'h0;
    mem_m_addr  = addr_q;
    mem_m_wdata = wdata_q;
  end

endmodule

// File: tb/tb_uart_mem_master.sv
// tb_uart_mem_master
// Self-checking bench for uart_mem_master (TIMEOUT = 16). A behavioural mem
// slave with programmable latency and a transmitter sink with selectable
// tx_ready behaviour surround the DUT; a word-level reference memory supplies
// the expected responses for randomized frames.

module tb_uart_mem_master;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_m_valid;
  logic [31:0] mem_m_addr;
  logic [31:0] mem_m_wdata;
  logic [3:0]  mem_m_wstrb;
  logic        mem_m_ready;
  logic [31:0] mem_m_rdata = 32'h0;
  logic        busy;
  logic        err_ovf;

  int checks = 0;
  int errors = 0;

  uart_mem_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .mem_m_valid (mem_m_valid),
    .mem_m_addr  (mem_m_addr),
    .mem_m_wdata (mem_m_wdata),
    .mem_m_wstrb (mem_m_wstrb),
    .mem_m_ready (mem_m_ready),
    .mem_m_rdata (mem_m_rdata),
    .busy        (busy),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  // Slave configuration, written only by the test sequence.
  int          slave_lat = 1;
  bit          slave_never = 1'b0;
  bit          rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr_val = 32'h0;

  // Slave: ready is asserted in the slave_lat-th cycle of valid (1 means
  // same-cycle combinational ready).
  int wait_cnt = 0;
  assign mem_m_ready = mem_m_valid && !slave_never && (wait_cnt >= slave_lat - 1);

  always @(posedge clk) begin
    if (!mem_m_valid || mem_m_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Bus monitor and slave storage, sampled on the falling edge.
  logic [31:0] slave_mem [bit [31:0]];
  logic [31:0] log_addr  [int];
  logic [31:0] log_wdata [int];
  logic [3:0]  log_wstrb [int];
  int          valid_cycles = 0;
  int          txn_count = 0;
  int          stable_errs = 0;
  bit          prev_valid = 1'b0;
  logic [67:0] prev_bus = '0;

  always @(negedge clk) begin
    if (mem_m_valid) begin
      valid_cycles++;
      if (prev_valid && ({mem_m_addr, mem_m_wdata, mem_m_wstrb} !== prev_bus)) stable_errs++;
      if (mem_m_ready) begin
        log_addr[txn_count]  = mem_m_addr;
        log_wdata[txn_count] = mem_m_wdata;
        log_wstrb[txn_count] = mem_m_wstrb;
        if (mem_m_wstrb == 4'hF) slave_mem[mem_m_addr] = mem_m_wdata;
        txn_count++;
      end
    end
    prev_valid = mem_m_valid && !mem_m_ready;
    prev_bus   = {mem_m_addr, mem_m_wdata, mem_m_wstrb};
    if (rd_ovr_en) mem_m_rdata = rd_ovr_val;
    else if (slave_mem.exists(mem_m_addr)) mem_m_rdata = slave_mem[mem_m_addr];
    else mem_m_rdata = 32'h0;
  end

  // Transmitter sink: tx_mode 0 = never ready, 1 = always ready, 2 = random.
  // A byte offered while tx_ready is high is accepted at the next rising edge.
  int          tx_mode = 1;
  int          tx_count = 0;
  logic [7:0]  tx_log [int];
  int          hold_errs = 0;
  bit          pend = 1'b0;
  logic [7:0]  pend_data = 8'h00;

  always @(negedge clk) begin
    if (pend && (!tx_valid || (tx_data !== pend_data))) hold_errs++;
    case (tx_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (tx_valid && tx_ready) begin
      tx_log[tx_count] = tx_data;
      tx_count++;
    end
    pend      = tx_valid && !tx_ready;
    pend_data = tx_data;
  end

  // Reference memory: a word per byte-address, as the host sees it.
  logic [31:0] ref_mem [bit [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Send n bytes (right-aligned in seq, first byte most significant) with a
  // random 0..max_gap idle cycles after each; rx_valid is dropped at the end.
  task automatic apply_stimulus(input logic [71:0] seq, input int n, input int max_gap);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = seq[8*(n-1-i) +: 8];
      g = $urandom_range(0, max_gap);
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_count >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({tx_valid, mem_m_valid, busy, err_ovf} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b, expected 0000", {tx_valid, mem_m_valid, busy, err_ovf}); end
    checks++; if ({tx_data, mem_m_wstrb} !== 12'h000) begin errors++; $display("[TB] FAIL reset_tx_wstrb: got %h, expected 000", {tx_data, mem_m_wstrb}); end
    checks++; if ({mem_m_addr, mem_m_wdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_addr_wdata: got %h, expected 0", {mem_m_addr, mem_m_wdata}); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({tx_valid, mem_m_valid, busy, err_ovf} !== 4'b0000) begin errors++; $display("[TB] FAIL post_reset_idle: got %b, expected 0000", {tx_valid, mem_m_valid, busy, err_ovf}); end
  endtask

  task automatic test_write();
    int bt, bv, bx; bit ok;
    bt = txn_count; bv = valid_cycles; bx = tx_count;
    slave_lat = 3;
    apply_stimulus(72'({8'h57, 32'h00001004, 32'hDEADBEEF}), 9, 1);
    wait_tx(bx + 1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL write_resp_wait: no response within budget"); end
    checks++; if (tx_log[bx] !== 8'h06) begin errors++; $display("[TB] FAIL write_ack: got %h, expected 06", tx_log[bx]); end
    checks++; if (txn_count - bt !== 1) begin errors++; $display("[TB] FAIL write_txn_count: got %0d, expected 1", txn_count - bt); end
    checks++; if (log_addr[bt] !== 32'h00001004) begin errors++; $display("[TB] FAIL write_addr: got %h, expected 00001004", log_addr[bt]); end
    checks++; if (log_wdata[bt] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_wdata: got %h, expected deadbeef", log_wdata[bt]); end
    checks++; if (log_wstrb[bt] !== 4'hF) begin errors++; $display("[TB] FAIL write_wstrb: got %h, expected f", log_wstrb[bt]); end
    checks++; if (valid_cycles - bv !== 3) begin errors++; $display("[TB] FAIL write_valid_width: got %0d, expected 3", valid_cycles - bv); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL write_idle: busy still %b", busy); end
  endtask

  task automatic test_read();
    int bt, bv, bx; bit ok;
    bt = txn_count; bv = valid_cycles; bx = tx_count;
    slave_lat = 1; rd_ovr_en = 1'b1; rd_ovr_val = 32'h12345678;
    apply_stimulus(72'({8'h52, 32'h80000008}), 5, 0);
    checks++; if ({mem_m_valid, mem_m_wstrb} !== 5'b1_0000) begin errors++; $display("[TB] FAIL read_valid_latency: got valid/wstrb %b, expected 10000", {mem_m_valid, mem_m_wstrb}); end
    checks++; if (mem_m_addr !== 32'h80000008) begin errors++; $display("[TB] FAIL read_addr: got %h, expected 80000008", mem_m_addr); end
    @(negedge clk);
    checks++; if ({mem_m_valid, tx_valid, tx_data} !== {2'b01, 8'h12}) begin errors++; $display("[TB] FAIL read_tx_latency: got %b/%b/%h, expected 0/1/12", mem_m_valid, tx_valid, tx_data); end
    wait_tx(bx + 4, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL read_resp_wait: only %0d bytes", tx_count - bx); end
    checks++; if ({tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]} !== 32'h12345678) begin errors++; $display("[TB] FAIL read_data: got %h, expected 12345678", {tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]}); end
    checks++; if (valid_cycles - bv !== 1) begin errors++; $display("[TB] FAIL read_valid_width: got %0d, expected 1", valid_cycles - bv); end
    checks++; if ((txn_count - bt !== 1) || (log_wstrb[bt] !== 4'h0)) begin errors++; $display("[TB] FAIL read_txn: got count %0d wstrb %h, expected 1 and 0", txn_count - bt, log_wstrb[bt]); end
    rd_ovr_en = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL read_idle: busy still %b", busy); end
  endtask

  task automatic test_bad_cmd();
    int bt, bv, bx; bit ok;
    logic [31:0] a, d;
    bt = txn_count; bv = valid_cycles; bx = tx_count;
    apply_stimulus(72'h41, 1, 0);
    wait_tx(bx + 1, ok);
    checks++; if (!ok || (tx_log[bx] !== 8'h15)) begin errors++; $display("[TB] FAIL bad_cmd_nak: got %h (ok=%b), expected 15", tx_log[bx], ok); end
    checks++; if ((txn_count - bt !== 0) || (valid_cycles - bv !== 0)) begin errors++; $display("[TB] FAIL bad_cmd_bus: got %0d txns %0d valid cycles, expected 0 0", txn_count - bt, valid_cycles - bv); end
    wait_idle(ok);
    a = 32'h00002000 | 32'($urandom_range(0, 255));
    d = $urandom;
    slave_lat = 2;
    bt = txn_count; bx = tx_count;
    apply_stimulus(72'({8'h57, a, d}), 9, 0);
    wait_tx(bx + 1, ok);
    checks++; if (!ok || (tx_log[bx] !== 8'h06) || (log_addr[bt] !== a) || (log_wdata[bt] !== d)) begin errors++; $display("[TB] FAIL after_nak_write: got ack %h addr %h data %h, expected 06 %h %h", tx_log[bx], log_addr[bt], log_wdata[bt], a, d); end
    wait_idle(ok);
    bx = tx_count;
    apply_stimulus(72'({8'h52, a}), 5, 0);
    wait_tx(bx + 4, ok);
    checks++; if (!ok || ({tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]} !== d)) begin errors++; $display("[TB] FAIL after_nak_readback: got %h, expected %h", {tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]}, d); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bad_cmd_idle: busy still %b", busy); end
  endtask

  task automatic test_timeout();
    int bt, bv, bx; bit ok;
    bt = txn_count; bv = valid_cycles; bx = tx_count;
    slave_never = 1'b1;
    apply_stimulus(72'({8'h52, 32'h00000040}), 5, 1);
    wait_tx(bx + 1, ok);
    checks++; if (!ok || (tx_log[bx] !== 8'h15)) begin errors++; $display("[TB] FAIL timeout_nak: got %h (ok=%b), expected 15", tx_log[bx], ok); end
    checks++; if (valid_cycles - bv !== TIMEOUT) begin errors++; $display("[TB] FAIL timeout_valid_width: got %0d, expected %0d", valid_cycles - bv, TIMEOUT); end
    checks++; if (txn_count - bt !== 0) begin errors++; $display("[TB] FAIL timeout_txn: got %0d, expected 0", txn_count - bt); end
    wait_idle(ok);
    checks++; if (!ok || (tx_count - bx !== 1)) begin errors++; $display("[TB] FAIL timeout_idle: busy %b bytes %0d, expected 0 and 1", busy, tx_count - bx); end
    slave_never = 1'b0;
  endtask

  task automatic test_random();
    int bt, bv, bx, kind, n; bit ok;
    logic [31:0] a, d, expv, got;
    logic [7:0] c;
    tx_mode = 2;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      a = 32'h40000000 | 32'($urandom_range(0, 7));
      d = $urandom;
      slave_lat = $urandom_range(1, 4);
      bt = txn_count; bv = valid_cycles; bx = tx_count;
      if (kind < 4) begin
        apply_stimulus(72'({8'h57, a, d}), 9, 2);
        ref_mem[a] = d; expv = 32'h06; n = 1;
      end else if (kind < 8) begin
        apply_stimulus(72'({8'h52, a}), 5, 2);
        expv = ref_read(a); n = 4;
      end else begin
        do c = 8'($urandom); while ((c == 8'h57) || (c == 8'h52));
        apply_stimulus(72'(c), 1, 2);
        expv = 32'h15; n = 1;
      end
      wait_tx(bx + n, ok);
      got = (n == 4) ? {tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]} : {24'h0, tx_log[bx]};
      checks++; if (!ok || (got !== expv)) begin errors++; $display("[TB] FAIL rand_resp[%0d]: got %h (ok=%b), expected %h", t, got, ok, expv); end
      if (kind < 8) begin
        checks++; if ((txn_count - bt !== 1) || (log_addr[bt] !== a) || (log_wstrb[bt] !== ((kind < 4) ? 4'hF : 4'h0))) begin errors++; $display("[TB] FAIL rand_bus[%0d]: got %0d txns addr %h wstrb %h, expected 1 %h kind %0d", t, txn_count - bt, log_addr[bt], log_wstrb[bt], a, kind); end
        checks++; if (valid_cycles - bv !== slave_lat) begin errors++; $display("[TB] FAIL rand_valid_width[%0d]: got %0d, expected %0d", t, valid_cycles - bv, slave_lat); end
        if (kind < 4) begin
          checks++; if (log_wdata[bt] !== d) begin errors++; $display("[TB] FAIL rand_wdata[%0d]: got %h, expected %h", t, log_wdata[bt], d); end
        end
      end else begin
        checks++; if ((txn_count - bt !== 0) || (valid_cycles - bv !== 0)) begin errors++; $display("[TB] FAIL rand_nak_bus[%0d]: got %0d txns, expected 0", t, txn_count - bt); end
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_idle[%0d]: busy still %b", t, busy); end
    end
    tx_mode = 1;
    checks++; if ({hold_errs, stable_errs} !== 64'h0) begin errors++; $display("[TB] FAIL rand_stability: got hold %0d bus %0d, expected 0 0", hold_errs, stable_errs); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rand_no_ovf: got %b, expected 0", err_ovf); end
  endtask

  task automatic test_backpressure();
    int bt, bx, bad; bit ok, seen;
    bt = txn_count; bx = tx_count; bad = 0; seen = 1'b0;
    rd_ovr_en = 1'b1; rd_ovr_val = 32'h12345678; slave_lat = 2;
    tx_mode = 0;
    apply_stimulus(72'({8'h52, 32'h80000008}), 5, 0);
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL bp_tx_valid: got 0, expected 1"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_valid = (i == 5);
      rx_data  = 8'hAA;
      if (!tx_valid || (tx_data !== 8'h12)) bad++;
    end
    rx_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d cycles not holding 12, expected 0", bad); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("[TB] FAIL bp_err_ovf: got %b, expected 1", err_ovf); end
    tx_mode = 1;
    wait_tx(bx + 4, ok);
    checks++; if (!ok || ({tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]} !== 32'h12345678)) begin errors++; $display("[TB] FAIL bp_data: got %h, expected 12345678", {tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]}); end
    wait_idle(ok);
    checks++; if (!ok || (txn_count - bt !== 1) || (tx_count - bx !== 4)) begin errors++; $display("[TB] FAIL bp_counts: got %0d txns %0d bytes, expected 1 4", txn_count - bt, tx_count - bx); end
    rd_ovr_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int bx; bit ok;
    logic [31:0] a, r;
    apply_stimulus(72'({8'h57, 16'h0000}), 3, 0);
    #2 resetn = 1'b0;
    #1;
    checks++; if ({tx_valid, mem_m_valid, busy, err_ovf, mem_m_wstrb} !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_outputs: got %b, expected 00000000", {tx_valid, mem_m_valid, busy, err_ovf, mem_m_wstrb}); end
    checks++; if ({mem_m_addr, tx_data} !== 40'h0) begin errors++; $display("[TB] FAIL mid_reset_addr: got %h, expected 0", {mem_m_addr, tx_data}); end
    @(negedge clk);
    resetn = 1'b1;
    a = $urandom; r = $urandom;
    rd_ovr_en = 1'b1; rd_ovr_val = r; slave_lat = 1;
    bx = tx_count;
    apply_stimulus(72'({8'h52, a}), 5, 1);
    wait_tx(bx + 4, ok);
    checks++; if (!ok || ({tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]} !== r)) begin errors++; $display("[TB] FAIL post_reset_read: got %h, expected %h", {tx_log[bx], tx_log[bx+1], tx_log[bx+2], tx_log[bx+3]}, r); end
    wait_idle(ok);
    rd_ovr_en = 1'b0;
    slave_never = 1'b1;
    apply_stimulus(72'({8'h52, 32'h00000100}), 5, 0);
    checks++; if (mem_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bus_before_reset: got %b, expected 1", mem_m_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({mem_m_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL async_valid_drop: got %b, expected 00", {mem_m_valid, busy}); end
    @(negedge clk);
    resetn = 1'b1;
    slave_never = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, tx_valid, mem_m_valid} !== 3'b000) begin errors++; $display("[TB] FAIL after_async_reset_idle: got %b, expected 000", {busy, tx_valid, mem_m_valid}); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting uart_mem_master bench");
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_random();
    test_backpressure();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
